seg_scan_driver: RTL and testbench

Time-multiplexed 3-digit seven-segment driver downstream of the timer stage. Consumes the timer's BCD outputs (tens, ones, tenths) and decimal-point flag, and drives one digit at a time at a programmable scan rate. Inputs are captured once per frame into shadow registers so a digit never shows a half-updated value. The block runs on the fast board clock, independent of the slow timing clocks.

---
 rtl/seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seg_scan_driver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit seven-segment driver with per-frame shadow capture.
// Optional leading-zero blanking of the tens digit: define SEG_LZB_EN.
module seg_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] xiaoshu,
  input  logic       point,
  output logic [2:0] dig,
  output logic [7:0] seg,
  output logic       frame
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       sh_tens, sh_ones, sh_xiaoshu;
  logic             sh_point;
  logic             tick;
  logic [2:0]       slot_dig;
  logic [7:0]       slot_seg;

  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_encode = 7'h3F;
      4'd1:    seg_encode = 7'h06;
      4'd2:    seg_encode = 7'h5B;
      4'd3:    seg_encode = 7'h4F;
      4'd4:    seg_encode = 7'h66;
      4'd5:    seg_encode = 7'h6D;
      4'd6:    seg_encode = 7'h7D;
      4'd7:    seg_encode = 7'h07;
      4'd8:    seg_encode = 7'h7F;
      4'd9:    seg_encode = 7'h6F;
      default: seg_encode = 7'h40;
    endcase
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] s);
    seg_pol = SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic [2:0] dig_pol(input logic [2:0] d);
    dig_pol = SEG_ACTIVE_LOW ? ~d : d;
  endfunction

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

  // The tens slot encodes the live inputs because they are captured on that same tick.
  always_comb begin
    slot_dig = 3'b000;
    slot_seg = 8'h00;
    case (idx)
      2'd2: begin
        slot_dig = 3'b100;
        slot_seg = {1'b0, seg_encode(tens)};
`ifdef SEG_LZB_EN
        if (tens == 4'd0) slot_seg = 8'h00;
`endif
      end
      2'd1: begin
        slot_dig = 3'b010;
        slot_seg = {sh_point, seg_encode(sh_ones)};
      end
      2'd0: begin
        slot_dig = 3'b001;
        slot_seg = {1'b0, seg_encode(sh_xiaoshu)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= 2'd2;
      sh_tens    <= '0;
      sh_ones    <= '0;
      sh_xiaoshu <= '0;
      sh_point   <= 1'b0;
      dig        <= dig_pol(3'b000);
      seg        <= seg_pol(8'h00);
      frame      <= 1'b0;
    end else if (!en) begin
      // Abort the scan mid-slot; shadows keep their contents.
      cnt   <= '0;
      idx   <= 2'd2;
      dig   <= dig_pol(3'b000);
      seg   <= seg_pol(8'h00);
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (tick) begin
        cnt   <= '0;
        dig   <= dig_pol(slot_dig);
        seg   <= seg_pol(slot_seg);
        frame <= (idx == 2'd2);
        idx   <= (idx == 2'd0) ? 2'd2 : idx - 2'd1;
        if (idx == 2'd2) begin
          sh_tens    <= tens;
          sh_ones    <= ones;
          sh_xiaoshu <= xiaoshu;
          sh_point   <= point;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV = 4, active-low outputs.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] tens, ones, xiaoshu;
  logic       point;
  logic [2:0] dig;
  logic [7:0] seg;
  logic       frame;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tens(tens), .ones(ones),
    .xiaoshu(xiaoshu), .point(point), .dig(dig), .seg(seg), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for two edges then release; the next edge counts as edge 1.
  task automatic restart();
    rst_n = 1'b0;
    en    = 1'b1;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    tens = 4'd2; ones = 4'd5; xiaoshu = 4'd7; point = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++;
      if (dig !== 3'b111) begin n_fail++; $display("FAIL reset_dig cyc%0d got %b exp 111", i, dig); end
      n_checks++;
      if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg cyc%0d got %h exp FF", i, seg); end
      n_checks++;
      if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame cyc%0d got %b exp 0", i, frame); end
    end
  endtask

  task automatic test_scan_sequence();
    tens = 4'd2; ones = 4'd5; xiaoshu = 4'd7; point = 1'b1;
    restart();
    step(3);
    n_checks++;
    if (dig !== 3'b111) begin n_fail++; $display("FAIL scan_pre_dig got %b exp 111", dig); end
    step(1); // edge 4
    n_checks++;
    if ({dig, seg, frame} !== {3'b011, 8'hA4, 1'b1}) begin
      n_fail++; $display("FAIL scan_e4 got dig=%b seg=%h frame=%b exp 011 A4 1", dig, seg, frame);
    end
    step(1); // edge 5
    n_checks++;
    if ({dig, seg, frame} !== {3'b011, 8'hA4, 1'b0}) begin
      n_fail++; $display("FAIL scan_e5 got dig=%b seg=%h frame=%b exp 011 A4 0", dig, seg, frame);
    end
    step(3); // edge 8
    n_checks++;
    if ({dig, seg, frame} !== {3'b101, 8'h12, 1'b0}) begin
      n_fail++; $display("FAIL scan_e8 got dig=%b seg=%h frame=%b exp 101 12 0", dig, seg, frame);
    end
    step(4); // edge 12
    n_checks++;
    if ({dig, seg, frame} !== {3'b110, 8'hF8, 1'b0}) begin
      n_fail++; $display("FAIL scan_e12 got dig=%b seg=%h frame=%b exp 110 F8 0", dig, seg, frame);
    end
    step(3); // edge 15
    n_checks++;
    if ({dig, frame} !== {3'b110, 1'b0}) begin
      n_fail++; $display("FAIL scan_e15 got dig=%b frame=%b exp 110 0", dig, frame);
    end
    step(1); // edge 16
    n_checks++;
    if ({dig, seg, frame} !== {3'b011, 8'hA4, 1'b1}) begin
      n_fail++; $display("FAIL scan_e16 got dig=%b seg=%h frame=%b exp 011 A4 1", dig, seg, frame);
    end
  endtask

  task automatic test_tear_free();
    tens = 4'd2; ones = 4'd5; xiaoshu = 4'd7; point = 1'b0;
    restart();
    step(6);
    ones = 4'd8;
    step(2); // edge 8: ones slot from the shadow (5, no dp)
    n_checks++;
    if ({dig, seg} !== {3'b101, 8'h92}) begin
      n_fail++; $display("FAIL tear_e8 got dig=%b seg=%h exp 101 92", dig, seg);
    end
    step(12); // edge 20: next frame's ones slot shows 8
    n_checks++;
    if ({dig, seg} !== {3'b101, 8'h80}) begin
      n_fail++; $display("FAIL tear_e20 got dig=%b seg=%h exp 101 80", dig, seg);
    end
  endtask

  task automatic test_invalid_code();
    tens = 4'd1; ones = 4'd3; xiaoshu = 4'hC; point = 1'b0;
    restart();
    step(12);
    n_checks++;
    if ({dig, seg} !== {3'b110, 8'hBF}) begin
      n_fail++; $display("FAIL invalid_tenths got dig=%b seg=%h exp 110 BF", dig, seg);
    end
  endtask

  task automatic test_enable_abort();
    tens = 4'd2; ones = 4'd5; xiaoshu = 4'd7; point = 1'b1;
    restart();
    step(10); // mid ones slot
    en = 1'b0;
    step(1);
    n_checks++;
    if ({dig, seg, frame} !== {3'b111, 8'hFF, 1'b0}) begin
      n_fail++; $display("FAIL abort_off got dig=%b seg=%h frame=%b exp 111 FF 0", dig, seg, frame);
    end
    step(2);
    en = 1'b1;
    step(3);
    n_checks++;
    if ({dig, frame} !== {3'b111, 1'b0}) begin
      n_fail++; $display("FAIL abort_wait got dig=%b frame=%b exp 111 0", dig, frame);
    end
    step(1);
    n_checks++;
    if ({dig, seg, frame} !== {3'b011, 8'hA4, 1'b1}) begin
      n_fail++; $display("FAIL abort_resume got dig=%b seg=%h frame=%b exp 011 A4 1", dig, seg, frame);
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] exp_seg;
`ifdef SEG_LZB_EN
    exp_seg = 8'hFF;
`else
    exp_seg = 8'hC0;
`endif
    tens = 4'd0; ones = 4'd4; xiaoshu = 4'd9; point = 1'b1;
    restart();
    step(4);
    n_checks++;
    if ({dig, seg} !== {3'b011, exp_seg}) begin
      n_fail++; $display("FAIL lzb_tens got dig=%b seg=%h exp 011 %h", dig, seg, exp_seg);
    end
    step(4); // ones 4 with dp: 66|80 = E6 -> 19
    n_checks++;
    if ({dig, seg} !== {3'b101, 8'h19}) begin
      n_fail++; $display("FAIL lzb_ones got dig=%b seg=%h exp 101 19", dig, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan_sequence();
    test_tear_free();
    test_invalid_code();
    test_enable_abort();
    test_leading_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
